ram_1kx8: RTL and testbench

//   Single-port synchronous 1024 x 8 data RAM with chip select and separate read/write strobes.

---
 rtl/ram_1kx8.sv | 70 +++++++
 tb/tb_ram_1kx8.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_1kx8.sv
// ram_1kx8: single-port 1024x8 synchronous RAM, registered read data.
// Optional RAM_PARITY_EN adds a stored parity bit per word and a parity_err flag.
module ram_1kx8 #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CS,
  input  logic              WRITE,
  input  logic              READ,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] dataIn,
  output logic [DATA_W-1:0] dataOut,
  output logic              parity_err
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_range;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] rdata;

  assign in_range = {1'b0, Addr} < LIMIT;
  assign wr_en    = CS & WRITE & in_range;
  // A write wins over a simultaneous read; the read is dropped.
  assign rd_en    = CS & READ & ~WRITE;
  assign rdata    = in_range ? mem[Addr] : '0;

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[Addr] <= dataIn;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dataOut <= '0;
    end else if (rd_en) begin
      dataOut <= rdata;
    end
  end

`ifdef RAM_PARITY_EN
  logic par_mem [DEPTH];
  logic rpar;

  assign rpar = in_range ? par_mem[Addr] : 1'b0;

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      par_mem[Addr] <= ^dataIn;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err <= 1'b0;
    end else if (rd_en) begin
      parity_err <= (^rdata) ^ rpar;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_1kx8.sv
// tb_ram_1kx8: randomized and directed checks of ram_1kx8
// against an array-based reference model.
module tb_ram_1kx8;

  logic       clk;
  logic       rst;
  logic       CS;
  logic       WRITE;
  logic       READ;
  logic [9:0] Addr;
  logic [7:0] dataIn;
  logic [7:0] dataOut;
  logic       parity_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] mdl [1024];
  bit         wrt [1024];
  logic [7:0] exp_q;

  ram_1kx8 dut (
    .clk(clk), .rst(rst), .CS(CS), .WRITE(WRITE), .READ(READ),
    .Addr(Addr), .dataIn(dataIn), .dataOut(dataOut),
    .parity_err(parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_op(input bit cs, input bit we, input bit re,
                       input logic [9:0] a, input logic [7:0] d);
    CS = cs; WRITE = we; READ = re; Addr = a; dataIn = d;
    @(posedge clk); #1;
    if (cs && we) begin
      mdl[a] = d;
      wrt[a] = 1'b1;
    end else if (cs && re) begin
      exp_q = mdl[a];
    end
    CS = 0; WRITE = 0; READ = 0;
  endtask

  task automatic test_reset();
    do_op(1, 1, 0, 10'd7, 8'h77);
    do_op(1, 0, 1, 10'd7, 8'h00);
    checks++;
    if (dataOut !== 8'h77) begin
      errors++;
      $display("FAIL pre_reset_read got %h want %h", dataOut, 8'h77);
    end
    rst = 1; CS = 1; WRITE = 1; Addr = 10'd7; dataIn = 8'h99;
    @(posedge clk); #1;
    WRITE = 0; READ = 1;
    @(posedge clk); #1;
    rst = 0; CS = 0; READ = 0;
    exp_q = 8'h00;
    checks++;
    if (dataOut !== 8'h00) begin
      errors++;
      $display("FAIL reset_dataout got %h want %h", dataOut, 8'h00);
    end
    checks++;
    if (parity_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_parity got %b want 0", parity_err);
    end
    do_op(1, 0, 1, 10'd7, 8'h00);
    checks++;
    if (dataOut !== 8'h77) begin
      errors++;
      $display("FAIL reset_dropped_write got %h want %h", dataOut, 8'h77);
    end
  endtask

  task automatic test_write_burst();
    logic [7:0] wd [6] = '{8'h00, 8'h01, 8'h12, 8'h13, 8'h16, 8'h02};
    logic [9:0] wa [6] = '{10'd0, 10'd0, 10'd1, 10'd2, 10'd3, 10'd4};
    logic [7:0] rd [5] = '{8'h01, 8'h12, 8'h13, 8'h16, 8'h02};
    for (int i = 0; i < 6; i++) do_op(1, 1, 0, wa[i], wd[i]);
    for (int i = 0; i < 5; i++) begin
      do_op(1, 0, 1, 10'(i), 8'h00);
      checks++;
      if (dataOut !== rd[i]) begin
        errors++;
        $display("FAIL burst_read%0d got %h want %h", i, dataOut, rd[i]);
      end
    end
  endtask

  task automatic test_chip_select();
    do_op(0, 1, 0, 10'd1, 8'hAA);
    do_op(1, 0, 1, 10'd1, 8'h00);
    checks++;
    if (dataOut !== 8'h12) begin
      errors++;
      $display("FAIL cs_write_blocked got %h want %h", dataOut, 8'h12);
    end
    do_op(0, 0, 1, 10'd3, 8'h00);
    checks++;
    if (dataOut !== 8'h12) begin
      errors++;
      $display("FAIL cs_read_hold got %h want %h", dataOut, 8'h12);
    end
  endtask

  task automatic test_simultaneous();
    do_op(1, 1, 1, 10'd3, 8'h5C);
    checks++;
    if (dataOut !== 8'h12) begin
      errors++;
      $display("FAIL both_strobes_hold got %h want %h", dataOut, 8'h12);
    end
    do_op(1, 0, 1, 10'd3, 8'h00);
    checks++;
    if (dataOut !== 8'h5C) begin
      errors++;
      $display("FAIL both_strobes_write got %h want %h", dataOut, 8'h5C);
    end
  endtask

  task automatic test_boundary();
    do_op(1, 1, 0, 10'd0, 8'hA5);
    do_op(1, 1, 0, 10'd1023, 8'h3C);
    do_op(1, 0, 1, 10'd0, 8'h00);
    checks++;
    if (dataOut !== 8'hA5) begin
      errors++;
      $display("FAIL bound_lo got %h want %h", dataOut, 8'hA5);
    end
    do_op(1, 0, 1, 10'd1023, 8'h00);
    checks++;
    if (dataOut !== 8'h3C) begin
      errors++;
      $display("FAIL bound_hi got %h want %h", dataOut, 8'h3C);
    end
  endtask

  task automatic test_random();
    int         k;
    logic [9:0] a;
    logic [7:0] d;
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 9);
      a = ($urandom_range(0, 7) == 0) ? 10'($urandom)
                                      : 10'($urandom_range(0, 15));
      d = 8'($urandom);
      if (k < 4 || (k < 8 && !wrt[a])) do_op(1, 1, 0, a, d);
      else if (k < 8) do_op(1, 0, 1, a, d);
      else if (k == 8)
        do_op(0, 1'($urandom), 1'($urandom), a, d);
      else do_op(1, 1, 1, a, d);
      checks++;
      if (dataOut !== exp_q) begin
        errors++;
        $display("FAIL rand%0d addr %0d got %h want %h",
                 i, a, dataOut, exp_q);
      end
      checks++;
      if (parity_err !== 1'b0) begin
        errors++;
        $display("FAIL rand_parity%0d got %b want 0", i, parity_err);
      end
    end
  endtask

  task automatic test_parity();
    do_op(1, 1, 0, 10'd2, 8'h13);
    do_op(1, 1, 0, 10'd1, 8'h12);
`ifdef RAM_PARITY_EN
    dut.par_mem[2] = ~dut.par_mem[2];
`endif
    do_op(1, 0, 1, 10'd2, 8'h00);
`ifdef RAM_PARITY_EN
    checks++;
    if (parity_err !== 1'b1) begin
      errors++;
      $display("FAIL parity_inject got %b want 1", parity_err);
    end
`else
    checks++;
    if (parity_err !== 1'b0) begin
      errors++;
      $display("FAIL parity_tied got %b want 0", parity_err);
    end
`endif
    checks++;
    if (dataOut !== 8'h13) begin
      errors++;
      $display("FAIL parity_data got %h want %h", dataOut, 8'h13);
    end
    do_op(1, 0, 1, 10'd1, 8'h00);
    checks++;
    if (parity_err !== 1'b0) begin
      errors++;
      $display("FAIL parity_clear got %b want 0", parity_err);
    end
  endtask

  initial begin
    rst = 1; CS = 0; WRITE = 0; READ = 0; Addr = '0; dataIn = '0;
    exp_q = 8'h00;
    for (int i = 0; i < 1024; i++) begin
      mdl[i] = 8'h00;
      wrt[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 0;
    test_reset();
    test_write_burst();
    test_chip_select();
    test_simultaneous();
    test_boundary();
    test_random();
    test_parity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
